// File: rtl/disp_source_scan_pkg.sv
// Shared display constants: reset pattern, CPU channel index, default scaling mask.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package disp_defs;

  localparam logic [31:0] DISP_RESET_VAL  = 32'hAA55_55AA;
  localparam int          CH_CPU          = 0;
  // ch1 carries the PC byte address; showing it >>2 gives the word address
  localparam logic [7:0]  DISP_SHIFT_MASK = 8'b0000_0010;

  // Quarter-scale a word: logical shift right by two, zero fill
  function automatic logic [31:0] scale4(input logic [31:0] w);
    return {2'b00, w[31:2]};
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Channel sequencer: follows switches, or auto-rotates every SCAN_DIV cycles.
// Latency: test_sel -> cur_sel in 1 cycle; sel_changed registered alongside cur_sel.
// Backpressure: none; freeze holds the scan position and counter while scanning.
module disp_scan_timer
  import disp_defs::*;
#(
  parameter int SELW     = 3,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_en,
  input  logic            freeze,
  input  logic [SELW-1:0] test_sel,
  output logic [SELW-1:0] cur_sel,
  output logic            sel_changed
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0]   scan_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [SELW-1:0] sel_nxt;

  // Next select/count: manual follow ignores freeze; auto-scan advances on counter wrap
  always_comb begin
    sel_nxt = cur_sel;
    cnt_nxt = scan_cnt;
    if (!scan_en) begin
      sel_nxt = test_sel;
      cnt_nxt = '0;
    end else if (!freeze) begin
      if (scan_cnt == CNT_LAST) begin
        cnt_nxt = '0;
        sel_nxt = cur_sel + SELW'(1);
      end else begin
        cnt_nxt = scan_cnt + CW'(1);
      end
    end
  end

  // Register select, counter and change pulse; pulse is high while cur_sel shows a new value
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel     <= '0;
      scan_cnt    <= '0;
      sel_changed <= 1'b0;
    end else begin
      cur_sel     <= sel_nxt;
      scan_cnt    <= cnt_nxt;
      sel_changed <= (sel_nxt != cur_sel);
    end
  end

endmodule

// File: rtl/disp_source_scan.sv
// Display-source selector: CPU latch or debug channels onto disp_num, with scaling and freeze.
// Latency: select -> disp_num 2 cycles; channel data / CPU bypass -> disp_num 1 cycle.
// Backpressure: none; freeze holds disp_num, CPU writes are always accepted.
module disp_source_scan
  import disp_defs::*;
#(
  parameter int                  DW         = 32,
  parameter int                  SELW       = 3,
  parameter logic [DW-1:0]       RESET_VAL  = DISP_RESET_VAL,
  parameter int                  SCAN_DIV   = 50_000_000,
  parameter logic [2**SELW-1:0]  SHIFT_MASK = DISP_SHIFT_MASK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_we,
  input  logic [DW-1:0]            cpu_data,
  input  logic [SELW-1:0]          test_sel,
  input  logic                     scan_en,
  input  logic                     freeze,
  input  logic [(2**SELW-1)*DW-1:0] ch_data,
  output logic [DW-1:0]            disp_num,
  output logic [SELW-1:0]          cur_sel,
  output logic                     sel_changed,
  output logic                     cpu_dirty
);

  localparam int NCH = 2**SELW;
  localparam logic [SELW-1:0] SEL_CPU = SELW'(CH_CPU);

  logic [DW-1:0] cpu_latch;
  logic [DW-1:0] words [NCH];
  logic          cpu_shown;

  disp_scan_timer #(
    .SELW     (SELW),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .scan_en     (scan_en),
    .freeze      (freeze),
    .test_sel    (test_sel),
    .cur_sel     (cur_sel),
    .sel_changed (sel_changed)
  );

  // ch0 bypasses the latch on a write so the new value shows one edge later
  assign words[0] = cpu_we ? cpu_data : cpu_latch;

  for (genvar k = 1; k < NCH; k++) begin : g_ch
    logic [DW-1:0] raw;
    assign raw      = ch_data[k*DW-1 -: DW];
    assign words[k] = SHIFT_MASK[k] ? {2'b00, raw[DW-1:2]} : raw;
  end

  assign cpu_shown = (cur_sel == SEL_CPU) && !freeze;

  // CPU latch captures every store regardless of what is displayed
  always_ff @(posedge clk) begin
    if (rst)         cpu_latch <= RESET_VAL;
    else if (cpu_we) cpu_latch <= cpu_data;
  end

  // Output register: selected word, held while frozen
  always_ff @(posedge clk) begin
    if (rst)          disp_num <= RESET_VAL;
    else if (!freeze) disp_num <= words[cur_sel];
  end

  // Dirty flag: store to a hidden latch sets it, showing the latch clears it (clear wins)
  always_ff @(posedge clk) begin
    if (rst)                                 cpu_dirty <= 1'b0;
    else if (cpu_shown)                      cpu_dirty <= 1'b0;
    else if (cpu_we && cur_sel != SEL_CPU)   cpu_dirty <= 1'b1;
  end

endmodule

// File: tb/tb_disp_source_scan.sv
module tb_disp_source_scan;
  localparam int DW = 32;
  localparam int SELW = 3;
  localparam int NCH = 8;

  logic                   clk = 1'b0;
  logic                   rst, cpu_we, scan_en, freeze;
  logic [DW-1:0]          cpu_data;
  logic [SELW-1:0]        test_sel;
  logic [(NCH-1)*DW-1:0]  ch_data;
  logic [DW-1:0]          disp_num;
  logic [SELW-1:0]        cur_sel;
  logic                   sel_changed, cpu_dirty;

  logic [DW-1:0] chv [1:NCH-1];

  int checks = 0;
  int errors = 0;
  int pulses;
  logic [DW-1:0]   exp_disp_q [$];
  logic [SELW-1:0] exp_sel_q  [$];
  logic [DW-1:0]   tog;

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int k = 1; k < NCH; k++) ch_data[k*DW-1 -: DW] = chv[k];
  end

  disp_source_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .test_sel(test_sel), .scan_en(scan_en), .freeze(freeze), .ch_data(ch_data),
    .disp_num(disp_num), .cur_sel(cur_sel), .sel_changed(sel_changed), .cpu_dirty(cpu_dirty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag);
    logic [DW-1:0] e;
    if (exp_disp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s observed empty-queue expected entry", tag);
    end else begin
      e = exp_disp_q.pop_front();
      chk(tag, disp_num, e);
    end
  endtask

  task automatic chk_sel(input string tag);
    logic [SELW-1:0] e;
    if (exp_sel_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s observed empty-queue expected entry", tag);
    end else begin
      e = exp_sel_q.pop_front();
      chk(tag, DW'(cur_sel), DW'(e));
    end
  endtask

  initial begin
    rst = 1'b1; cpu_we = 1'b0; cpu_data = '0; test_sel = '0; scan_en = 1'b0; freeze = 1'b0;
    chv[1] = 32'h0000_0010;
    for (int k = 2; k < NCH; k++) chv[k] = {8{4'(k)}};

    // 1: reset
    tick(); tick();
    exp_disp_q.push_back(32'hAA55_55AA);
    chk_disp("reset_disp");
    chk("reset_sel", DW'(cur_sel), 0);
    chk("reset_dirty", DW'(cpu_dirty), 0);
    chk("reset_chg", DW'(sel_changed), 0);
    rst = 1'b0;
    tick();

    // 2: manual select of ch1 with >>2 scaling
    test_sel = 3'd1;
    exp_sel_q.push_back(3'd1);
    exp_disp_q.push_back(32'h0000_0004);
    pulses = 0;
    tick();
    pulses += int'(sel_changed);
    chk_sel("man_sel_lat1");
    tick();
    pulses += int'(sel_changed);
    chk_disp("man_disp_lat2");
    tick(); pulses += int'(sel_changed);
    tick(); pulses += int'(sel_changed);
    chk("man_chg_once", pulses, 1);

    // 3: CPU bypass, dirty set on hidden write, cleared when shown
    test_sel = 3'd0;
    tick(); tick();
    cpu_we = 1'b1; cpu_data = 32'h1234_5678;
    exp_disp_q.push_back(32'h1234_5678);
    tick();
    cpu_we = 1'b0;
    chk_disp("cpu_bypass");
    chk("cpu_clean", DW'(cpu_dirty), 0);
    test_sel = 3'd2;
    tick();
    cpu_we = 1'b1; cpu_data = 32'hDEAD_BEEF;
    exp_disp_q.push_back(32'h2222_2222);
    tick();
    cpu_we = 1'b0;
    chk("cpu_dirty_set", DW'(cpu_dirty), 1);
    chk_disp("ch2_disp");
    test_sel = 3'd0;
    exp_disp_q.push_back(32'hDEAD_BEEF);
    tick(); tick();
    chk_disp("cpu_latch_shown");
    chk("cpu_dirty_clr", DW'(cpu_dirty), 0);

    // 4: auto-scan wrap 6,7,0,1
    test_sel = 3'd6;
    tick(); tick();
    scan_en = 1'b1;
    for (int i = 1; i <= 15; i++) exp_sel_q.push_back(SELW'((6 + i / 4) % 8));
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      pulses += int'(sel_changed);
      chk_sel($sformatf("scan_sel_%0d", i));
      if (i == 5) begin
        exp_disp_q.push_back(32'h7777_7777);
        chk_disp("scan_disp_ch7");
      end
    end
    chk("scan_chg_cnt", pulses, 3);

    // 5: freeze at cur_sel=3, scan_cnt=2 with ch3 toggling
    for (int i = 16; i <= 22; i++) tick();
    chk("frz_pre_sel", DW'(cur_sel), 3);
    freeze = 1'b1;
    tog = 32'hF0F0_F0F0;
    for (int i = 0; i < 5; i++) begin
      chv[3] = tog;
      tick();
      exp_disp_q.push_back(32'h3333_3333);
      exp_sel_q.push_back(3'd3);
      chk_disp($sformatf("frz_disp_%0d", i));
      chk_sel($sformatf("frz_sel_%0d", i));
      tog = ~tog;
    end
    freeze = 1'b0;
    exp_sel_q.push_back(3'd3);
    exp_disp_q.push_back(~tog);
    tick();
    chk_sel("rel_sel_1");
    chk_disp("rel_disp_1");
    exp_sel_q.push_back(3'd4);
    tick();
    chk_sel("rel_sel_2");

    // 6: reset during freeze with dirty set
    cpu_we = 1'b1; cpu_data = 32'h0000_0055;
    tick();
    cpu_we = 1'b0;
    chk("rst6_dirty_pre", DW'(cpu_dirty), 1);
    freeze = 1'b1;
    tick();
    rst = 1'b1;
    exp_disp_q.push_back(32'hAA55_55AA);
    tick();
    chk_disp("rst6_disp");
    chk("rst6_sel", DW'(cur_sel), 0);
    chk("rst6_dirty", DW'(cpu_dirty), 0);
    chk("rst6_chg", DW'(sel_changed), 0);
    rst = 1'b0; freeze = 1'b0; scan_en = 1'b0; test_sel = 3'd0;
    exp_disp_q.push_back(32'hAA55_55AA);
    tick(); tick();
    chk_disp("rst6_latch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
